// File: rtl/stage_writeback.sv
// Writeback stage: registers the retiring instruction and drives the regfile
// write port, applying ISA destination rules and the multdiv completion handshake.
module stage_writeback #(
  parameter logic [4:0] REG_EXC  = 5'd30,
  parameter logic [4:0] REG_LINK = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] insn_in,
  input  logic [31:0] alu_result,
  input  logic        ovf_in,
  input  logic [31:0] mem_data,
  input  logic [31:0] pc_plus1,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_rdy,
  output logic        md_busy,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [0:0] {IDLE = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [4:0]  md_rd_r, md_rd_s;
  logic        md_div_r, md_div_s;
  logic        we_r, we_s;
  logic [4:0]  wreg_r, wreg_s;
  logic [31:0] wdata_r, wdata_s;
  logic        busy_r, busy_s;

  logic [4:0]  opcode_s, rd_s, aluop_s;
  logic        wr_s, exc_s;
  logic [4:0]  dest_s;
  logic [31:0] data_s;

  assign opcode_s = insn_in[31:27];
  assign rd_s     = insn_in[26:22];
  assign aluop_s  = insn_in[6:2];

  function automatic logic is_muldiv(input logic [4:0] op, input logic [4:0] alu);
    return (op == OP_RTYPE) && ((alu == ALU_MUL) || (alu == ALU_DIV));
  endfunction

  // Next-state, destination selection and write-port/stall values for the next cycle
  always_comb begin
    state_s  = state_r;
    md_rd_s  = md_rd_r;
    md_div_s = md_div_r;
    busy_s   = 1'b0;
    wr_s     = 1'b0;
    exc_s    = 1'b0;
    dest_s   = 5'd0;
    data_s   = 32'd0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (is_muldiv(opcode_s, aluop_s)) begin
            state_s  = MD_WAIT;
            md_rd_s  = rd_s;
            md_div_s = (aluop_s == ALU_DIV);
            busy_s   = 1'b1;
          end else begin
            case (opcode_s)
              OP_RTYPE: begin
                wr_s = 1'b1;
                if (ovf_in && (aluop_s == ALU_ADD)) begin
                  exc_s  = 1'b1;
                  data_s = 32'd1;
                end else if (ovf_in && (aluop_s == ALU_SUB)) begin
                  exc_s  = 1'b1;
                  data_s = 32'd3;
                end else begin
                  dest_s = rd_s;
                  data_s = alu_result;
                end
              end
              OP_ADDI: begin
                wr_s = 1'b1;
                if (ovf_in) begin
                  exc_s  = 1'b1;
                  data_s = 32'd2;
                end else begin
                  dest_s = rd_s;
                  data_s = alu_result;
                end
              end
              OP_LW: begin
                wr_s   = 1'b1;
                dest_s = rd_s;
                data_s = mem_data;
              end
              OP_JAL: begin
                wr_s   = 1'b1;
                dest_s = REG_LINK;
                data_s = pc_plus1;
              end
              OP_SETX: begin
                wr_s   = 1'b1;
                dest_s = REG_EXC;
                data_s = {5'b00000, insn_in[26:0]};
              end
              default: begin
                wr_s = 1'b0;
              end
            endcase
          end
        end else begin
          state_s = IDLE;
        end
      end
      MD_WAIT: begin
        if (md_rdy) begin
          state_s = IDLE;
          wr_s    = 1'b1;
          if (md_exception) begin
            exc_s  = 1'b1;
            data_s = md_div_r ? 32'd5 : 32'd4;
          end else begin
            dest_s = md_rd_r;
            data_s = md_result;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Exceptions always land in rstatus; ordinary writes to $r0 are dropped
    if (exc_s) begin
      dest_s = REG_EXC;
      we_s   = 1'b1;
    end else begin
      we_s = wr_s && (dest_s != 5'd0);
    end
    wreg_s  = dest_s;
    wdata_s = data_s;
  end

  // State, latched multdiv destination and registered write-port outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      md_rd_r  <= 5'd0;
      md_div_r <= 1'b0;
      we_r     <= 1'b0;
      wreg_r   <= 5'd0;
      wdata_r  <= 32'd0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      md_rd_r  <= md_rd_s;
      md_div_r <= md_div_s;
      we_r     <= we_s;
      wreg_r   <= wreg_s;
      wdata_r  <= wdata_s;
      busy_r   <= busy_s;
    end
  end

  assign md_busy          = busy_r;
  assign ctrl_writeEnable = we_r;
  assign ctrl_writeReg    = wreg_r;
  assign data_writeReg    = wdata_r;

endmodule

// File: tb/tb_stage_writeback.sv
// Directed vector bench for stage_writeback: single-cycle write rules from a
// table, then hand-written multdiv handshake and reset sequences.
module tb_stage_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] insn_in;
  logic [31:0] alu_result;
  logic        ovf_in;
  logic [31:0] mem_data;
  logic [31:0] pc_plus1;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_rdy;
  logic        md_busy;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int failures = 0;

  stage_writeback dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .insn_in(insn_in),
    .alu_result(alu_result), .ovf_in(ovf_in), .mem_data(mem_data),
    .pc_plus1(pc_plus1), .md_result(md_result), .md_exception(md_exception),
    .md_rdy(md_rdy), .md_busy(md_busy), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] alu;
    logic        ovf;
    logic [31:0] mem;
    logic [31:0] pc1;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] aluop);
    return {op, rd, 15'd0, aluop, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; insn_in = 32'd0; alu_result = 32'd0; ovf_in = 1'b0;
    mem_data = 32'd0; pc_plus1 = 32'd0; md_result = 32'd0;
    md_exception = 1'b0; md_rdy = 1'b0;
  endtask

  task automatic issue(input logic [31:0] insn);
    idle_inputs();
    in_valid = 1'b1;
    insn_in  = insn;
  endtask

  initial begin
    vecs[0]  = '{1'b1, mk(5'b00000, 5'd5, 5'b00000), 32'hAA, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hAA};
    vecs[1]  = '{1'b1, mk(5'b00101, 5'd7, 5'b00000), 32'h7FFF_FFFF, 1'b1, 32'h0, 32'h0, 1'b1, 5'd30, 32'd2};
    vecs[2]  = '{1'b1, mk(5'b00000, 5'd4, 5'b00001), 32'h8000_0000, 1'b1, 32'h0, 32'h0, 1'b1, 5'd30, 32'd3};
    vecs[3]  = '{1'b1, mk(5'b01000, 5'd0, 5'b00000), 32'h0, 1'b0, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[4]  = '{1'b1, mk(5'b00011, 5'd0, 5'b00000), 32'h0, 1'b0, 32'h0, 32'h10, 1'b1, 5'd31, 32'h10};
    vecs[5]  = '{1'b1, {5'b10101, 27'h000_1234}, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd30, 32'h1234};
    vecs[6]  = '{1'b1, mk(5'b00111, 5'd6, 5'b00000), 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b1, mk(5'b10110, 5'd0, 5'b00000), 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[8]  = '{1'b1, mk(5'b00000, 5'd6, 5'b00010), 32'h55, 1'b1, 32'h0, 32'h0, 1'b1, 5'd6, 32'h55};
    vecs[9]  = '{1'b1, mk(5'b01000, 5'd8, 5'b00000), 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd8, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, mk(5'b00000, 5'd0, 5'b00000), 32'h99, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[11] = '{1'b1, mk(5'b00000, 5'd0, 5'b00000), 32'h99, 1'b1, 32'h0, 32'h0, 1'b1, 5'd30, 32'd1};
    vecs[12] = '{1'b0, mk(5'b00000, 5'd5, 5'b00000), 32'h99, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[13] = '{1'b1, mk(5'b00001, 5'd5, 5'b00000), 32'h11, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[14] = '{1'b1, mk(5'b00100, 5'd5, 5'b00000), 32'h11, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[15] = '{1'b1, mk(5'b11111, 5'd5, 5'b00000), 32'h11, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[16] = '{1'b1, mk(5'b00101, 5'd12, 5'b00000), 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 1'b1, 5'd12, 32'hFFFF_FFFE};
    vecs[17] = '{1'b1, mk(5'b00000, 5'd1, 5'b00001), 32'h0000_0042, 1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 32'h42};

    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("reset_reg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("reset_data", data_writeReg, 32'd0);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);

    // Table vectors, applied back to back
    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      in_valid = vecs[i].valid; insn_in = vecs[i].insn; alu_result = vecs[i].alu;
      ovf_in = vecs[i].ovf; mem_data = vecs[i].mem; pc_plus1 = vecs[i].pc1;
      tick();
      chk($sformatf("v%0d_we", i), {31'd0, ctrl_writeEnable}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("v%0d_reg", i), {27'd0, ctrl_writeReg}, {27'd0, vecs[i].wreg});
        chk($sformatf("v%0d_data", i), data_writeReg, vecs[i].wdata);
      end
      chk($sformatf("v%0d_busy", i), {31'd0, md_busy}, 32'd0);
    end
    idle_inputs();
    tick();
    chk("idle_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // mul rd=9, result after 4 busy cycles, then an add in the write cycle
    issue(mk(5'b00000, 5'd9, 5'b00110));
    tick();
    idle_inputs();
    chk("mul_accept_we", {31'd0, ctrl_writeEnable}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mul_busy%0d", c), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mul_nowe%0d", c), {31'd0, ctrl_writeEnable}, 32'd0);
      if (c == 3) begin
        md_rdy = 1'b1; md_result = 32'h64;
      end
      tick();
    end
    chk("mul_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("mul_reg", {27'd0, ctrl_writeReg}, 32'd9);
    chk("mul_data", data_writeReg, 32'h64);
    chk("mul_busy_drop", {31'd0, md_busy}, 32'd0);
    issue(mk(5'b00000, 5'd2, 5'b00000));
    alu_result = 32'h77;
    tick();
    idle_inputs();
    chk("b2b_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("b2b_reg", {27'd0, ctrl_writeReg}, 32'd2);
    chk("b2b_data", data_writeReg, 32'h77);
    tick();
    chk("b2b_once", {31'd0, ctrl_writeEnable}, 32'd0);

    // div and mul exceptions land in rstatus with codes 5 and 4
    for (int k = 0; k < 2; k++) begin
      issue(mk(5'b00000, 5'd3, (k == 0) ? 5'b00111 : 5'b00110));
      tick();
      idle_inputs();
      chk($sformatf("exc%0d_busy", k), {31'd0, md_busy}, 32'd1);
      md_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF;
      tick();
      idle_inputs();
      chk($sformatf("exc%0d_we", k), {31'd0, ctrl_writeEnable}, 32'd1);
      chk($sformatf("exc%0d_reg", k), {27'd0, ctrl_writeReg}, 32'd30);
      chk($sformatf("exc%0d_data", k), data_writeReg, (k == 0) ? 32'd5 : 32'd4);
      tick();
    end

    // Reset while waiting on multdiv; later md_rdy must be ignored
    issue(mk(5'b00000, 5'd9, 5'b00110));
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wait_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_wait_we", {31'd0, ctrl_writeEnable}, 32'd0);
    md_rdy = 1'b1; md_result = 32'h1111;
    tick();
    md_rdy = 1'b0;
    chk("stray_rdy_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("stray_rdy_busy", {31'd0, md_busy}, 32'd0);
    tick();
    chk("stray_rdy_we2", {31'd0, ctrl_writeEnable}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Final pipeline stage of the 5-stage processor; the write-side counterpart to the decode stage's register read ports.
- Registers the retiring instruction and drives the regfile write port: ctrl_writeEnable, ctrl_writeReg, data_writeReg.
- Applies ISA destination rules: rd, $r31 for jal, and $r30 for setx and exceptions.
- Owns the multdiv completion handshake. It stalls upstream while a mul/div is outstanding and writes the result when the unit reports ready.

Parameters:
- REG_EXC, 30, exception/status register index (rstatus).
- REG_LINK, 31, jal link register index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  retiring instruction presented this cycle.
- insn_in  in  32  instruction: opcode [31:27], rd [26:22], ALU op [6:2], target [26:0].
- alu_result  in  32  ALU output for the instruction.
- ovf_in  in  1  ALU overflow for add/addi/sub.
- mem_data  in  32  load data for lw.
- pc_plus1  in  32  PC+1 of the instruction, for jal.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv exception (overflow or divide-by-zero).
- md_rdy  in  1  multdiv result valid, one-cycle pulse.
- md_busy  out  1  stall request to upstream stages.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write address.
- data_writeReg  out  32  regfile write data.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset has priority over all other inputs.
- Outputs are registered. An instruction accepted at edge N drives the write port during cycle N+1. ctrl_writeEnable is high for exactly one cycle per write.
- Write rules, evaluated on acceptance in IDLE:
  - R-type (opcode 00000), ALU op not mul/div: rd ← alu_result. If ovf_in and ALU op is add (00000), write REG_EXC ← 1 instead. If ovf_in and ALU op is sub (00001), write REG_EXC ← 3 instead.
  - addi (00101): rd ← alu_result. If ovf_in, write REG_EXC ← 2 instead.
  - lw (01000): rd ← mem_data.
  - jal (00011): REG_LINK ← pc_plus1.
  - setx (10101): REG_EXC ← {5'b0, insn_in[26:0]}.
  - sw, j, bne, jr, blt, bex, and undefined opcodes: no write; ctrl_writeEnable stays 0.
- $r0: any non-exception write with destination 0 is suppressed (enable 0). Exception writes target REG_EXC and are never suppressed.
- ovf_in is ignored for all opcodes other than add, sub and addi.
- State machine:
  - IDLE → MD_WAIT when in_valid and the instruction is R-type with ALU op 00110 (mul) or 00111 (div). Latch rd and the op kind; no write is issued. md_busy rises in the cycle after acceptance.
  - MD_WAIT: md_busy = 1. in_valid is ignored; upstream guarantees it is 0.
  - MD_WAIT → IDLE on md_rdy. The next cycle writes latched rd ← md_result. If md_exception, it writes REG_EXC ← 4 (mul) or 5 (div) instead. md_busy drops in that same write cycle.
  - md_rdy in IDLE is ignored.
  - md_busy is registered: 0 in IDLE and in the write cycle, 1 in every MD_WAIT cycle.
  - An instruction accepted in the cycle md_busy falls is processed normally, giving back-to-back writes.
- Reset during MD_WAIT: return to IDLE with md_busy = 0 and no write. A later md_rdy is ignored.
- Back-to-back in_valid in IDLE gives one write per cycle, no bubbles.

Test Plan:
- Reset, then R-type add rd=5 with alu_result=0x0000_00AA and ovf_in=0 → next cycle: WE=1, writeReg=5, data=0xAA; following cycle WE=0.
- addi rd=7 with ovf_in=1 → WE=1, writeReg=30, data=2. sub with ovf_in=1 → writeReg=30, data=3. lw rd=0 with mem_data=0x1234 → WE=0.
- jal with pc_plus1=0x0000_0010 → writeReg=31, data=0x10. setx target=0x000_1234 → writeReg=30, data=0x1234. sw and bex → WE=0.
- mul rd=9, md_rdy asserted 4 cycles later with md_result=0x64 → md_busy high for 4 cycles. Then the write cycle: WE=1, writeReg=9, data=0x64, md_busy=0. An add accepted in that cycle writes on the next cycle.
- div rd=3, md_rdy with md_exception=1 → writeReg=30, data=5. mul variant → data=4.
- mul accepted, reset asserted in MD_WAIT, then md_rdy pulse → md_busy=0 and no write. A stray md_rdy in IDLE also causes no write.
